seq_arb: RTL

SEQ_ARB -- requirements
Module: seq_arb

---
 rtl/seq_arb.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/seq_arb.sv
// seq_arb: round-robin arbiter feeding a pattern sequencer.
//
// Requesters present a level request and a pattern. The arbiter grants one
// requester at a time. It latches that requester's pattern onto SEQ_PTN and
// strobes SEQ_CLR. It then walks the pattern's steps from SEQ_CNT down to 0.
// Each step k dwells for (dwell_k + 1) cycles. DONE pulses once when the last
// step completes. ABORT ends a grant early and produces no DONE.
//
// Ports
//   RSTX     in   1          asynchronous active-low reset
//   CLK      in   1          clock, rising edge
//   REQ      in   N_REQ      level request per requester
//   PTN_IN   in   W*N_REQ    requester i pattern at [W*i +: W]
//   ABORT    in   1          terminate current grant without DONE
//   GNT      out  N_REQ      one-hot registered grant
//   DONE     out  1          one-cycle completion pulse
//   BUSY     out  1          high whenever the arbiter is not idle
//   SEQ_CLR  out  1          one-cycle load/restart strobe to the sequencer
//   SEQ_PTN  out  W          pattern latched from the granted requester
module seq_arb #(
    parameter int N_REQ      = 2,
    parameter int BW_SEQ     = 4,
    parameter int SEQ_CNT    = 7,
    parameter int BW_STEP    = 3,
    parameter int BW_TIMEOUT = 2,
    localparam int W         = (BW_SEQ + BW_TIMEOUT) * (SEQ_CNT + 1)
) (
    input  logic               RSTX,
    input  logic               CLK,
    input  logic [N_REQ-1:0]   REQ,
    input  logic [W*N_REQ-1:0] PTN_IN,
    input  logic               ABORT,
    output logic [N_REQ-1:0]   GNT,
    output logic               DONE,
    output logic               BUSY,
    output logic               SEQ_CLR,
    output logic [W-1:0]       SEQ_PTN
);

    localparam int ENT_W = BW_SEQ + BW_TIMEOUT;
    localparam int IW    = $clog2(N_REQ);
    localparam logic [BW_STEP-1:0] STEP_MAX = BW_STEP'(SEQ_CNT);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, FIN} state_t;

    state_t                state_q, state_d;
    logic [N_REQ-1:0]      gnt_q, gnt_d;
    logic [W-1:0]          ptn_q, ptn_d;
    logic                  clr_q, clr_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic [BW_STEP-1:0]    step_q, step_d;
    logic [BW_TIMEOUT-1:0] dwell_q, dwell_d;
    logic [IW-1:0]         last_q, last_d;
    logic [IW-1:0]         owner_q, owner_d;
    logic [IW-1:0]         win_idx;
    logic                  win_found;

    // Dwell field of step k sits in the low bits of that step's entry.
    function automatic logic [BW_TIMEOUT-1:0] dwell_of(input logic [W-1:0] ptn,
                                                       input logic [BW_STEP-1:0] k);
        dwell_of = ptn[ENT_W*int'(k) +: BW_TIMEOUT];
    endfunction

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        int idx;
        idx       = 0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int off = 1; off <= N_REQ; off++) begin
            idx = (int'(last_q) + off) % N_REQ;
            if (!win_found && REQ[idx]) begin
                win_found = 1'b1;
                win_idx   = IW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptn_d   = ptn_q;
        clr_d   = 1'b0;
        step_d  = step_q;
        dwell_d = dwell_q;
        last_d  = last_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = LOAD;
                    gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
                    ptn_d   = PTN_IN[W*int'(win_idx) +: W];
                    clr_d   = 1'b1;
                    owner_d = win_idx;
                end
            end
            LOAD: begin
                if (ABORT) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    last_d  = owner_q;
                end else begin
                    state_d = RUN;
                    step_d  = STEP_MAX;
                    dwell_d = dwell_of(ptn_q, STEP_MAX);
                end
            end
            RUN: begin
                // ABORT takes priority over a completion on the same cycle.
                if (ABORT) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    last_d  = owner_q;
                end else if (dwell_q != '0) begin
                    dwell_d = dwell_q - BW_TIMEOUT'(1);
                end else if (step_q != '0) begin
                    step_d  = step_q - BW_STEP'(1);
                    dwell_d = dwell_of(ptn_q, step_q - BW_STEP'(1));
                end else begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
                gnt_d   = '0;
                last_d  = owner_q;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
        // DONE and BUSY are registered views of the next state.
        done_d = (state_d == FIN);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptn_q   <= '0;
            clr_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            step_q  <= '0;
            dwell_q <= '0;
            last_q  <= IW'(N_REQ - 1);
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptn_q   <= ptn_d;
            clr_q   <= clr_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            step_q  <= step_d;
            dwell_q <= dwell_d;
            last_q  <= last_d;
            owner_q <= owner_d;
        end
    end

    assign GNT     = gnt_q;
    assign DONE    = done_q;
    assign BUSY    = busy_q;
    assign SEQ_CLR = clr_q;
    assign SEQ_PTN = ptn_q;

endmodule
